// File: rtl/game_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : game_pkg                                                        |
// | Desc     : Shared player state type, default constants and sizing helper.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } player_state_t;

    localparam int c_MAX_HEALTH_DEFAULT    = 3;
    localparam int c_INVULN_FRAMES_DEFAULT = 60;
    localparam int c_BLINK_BIT_DEFAULT     = 2;

    // Timer must hold INVULN_FRAMES-1 and also expose the blink bit.
    function automatic int timer_width(input int frames, input int blink_bit);
        int w;
        w = $clog2(frames);
        if (w < 1)
            w = 1;
        if (w < blink_bit + 1)
            w = blink_bit + 1;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/box_overlap.sv
// +----------------------------------------------------------------------------+
// | Module   : box_overlap                                                     |
// | Desc     : Combinational centre/half-size box intersection test.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module box_overlap #(
    parameter int W = 10
) (
    input  logic         i_enable,
    input  logic [W-1:0] i_ax,
    input  logic [W-1:0] i_ay,
    input  logic [W-1:0] i_as,
    input  logic [W-1:0] i_bx,
    input  logic [W-1:0] i_by,
    input  logic [W-1:0] i_bs,
    output logic         o_overlap
);

    logic [W:0] w_ax, w_ay, w_as, w_bx, w_by, w_bs;
    logic [W:0] w_dx, w_dy, w_sum;

    // One extra bit so the size sum cannot wrap and the difference stays exact.
    assign w_ax  = {1'b0, i_ax};
    assign w_ay  = {1'b0, i_ay};
    assign w_as  = {1'b0, i_as};
    assign w_bx  = {1'b0, i_bx};
    assign w_by  = {1'b0, i_by};
    assign w_bs  = {1'b0, i_bs};

    assign w_dx  = (w_ax >= w_bx) ? (w_ax - w_bx) : (w_bx - w_ax);
    assign w_dy  = (w_ay >= w_by) ? (w_ay - w_by) : (w_by - w_ay);
    assign w_sum = w_as + w_bs;

    // Strict compare: boxes whose edges just touch do not collide.
    assign o_overlap = i_enable && (w_dx < w_sum) && (w_dy < w_sum);

endmodule

`default_nettype wire

// File: rtl/player_damage.sv
// +----------------------------------------------------------------------------+
// | Module   : player_damage                                                   |
// | Desc     : Bullet hit responder with health, invulnerability and death.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module player_damage
    import game_pkg::*;
#(
    parameter int MAX_HEALTH    = c_MAX_HEALTH_DEFAULT,
    parameter int INVULN_FRAMES = c_INVULN_FRAMES_DEFAULT,
    parameter int BLINK_BIT     = c_BLINK_BIT_DEFAULT
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       round_start,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    input  logic [9:0] BulletX,
    input  logic [9:0] BulletY,
    input  logic [9:0] BulletS,
    input  logic       bullet_on,
    output logic       player_hit,
    output logic [2:0] health,
    output logic       invuln,
    output logic       visible,
    output logic       player_dead
);

    localparam int         c_TW          = timer_width(INVULN_FRAMES, BLINK_BIT);
    localparam logic [2:0] c_HEALTH_FULL = 3'(MAX_HEALTH);
    localparam logic [c_TW-1:0] c_TIMER_LOAD = c_TW'(INVULN_FRAMES - 1);

    player_state_t   r_state, w_state_nxt;
    logic [2:0]      r_health, w_health_nxt;
    logic [c_TW-1:0] r_timer, w_timer_nxt;
    logic            r_hit, w_hit_nxt;
    logic            w_overlap;
    logic            w_hit_ok;

    box_overlap #(
        .W (10)
    ) u_box_overlap (
        .i_enable  (bullet_on),
        .i_ax      (BallX),
        .i_ay      (BallY),
        .i_as      (BallS),
        .i_bx      (BulletX),
        .i_by      (BulletY),
        .i_bs      (BulletS),
        .o_overlap (w_overlap)
    );

    // Blocking a repeat pulse covers the frame the bullet needs to despawn.
    assign w_hit_ok = w_overlap && (r_state != DEAD) && !r_hit;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= ALIVE;
            r_health <= c_HEALTH_FULL;
            r_timer  <= '0;
            r_hit    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_health <= w_health_nxt;
            r_timer  <= w_timer_nxt;
            r_hit    <= w_hit_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_health_nxt = r_health;
        w_timer_nxt  = r_timer;
        w_hit_nxt    = w_hit_ok;

        if (round_start) begin
            w_state_nxt  = ALIVE;
            w_health_nxt = c_HEALTH_FULL;
            w_timer_nxt  = '0;
            w_hit_nxt    = 1'b0;
        end else begin
            case (r_state)
                ALIVE: begin
                    if (w_hit_ok) begin
                        if (r_health <= 3'd1) begin
                            w_state_nxt  = DEAD;
                            w_health_nxt = 3'd0;
                        end else begin
                            w_state_nxt  = INVULN;
                            w_health_nxt = r_health - 3'd1;
                            w_timer_nxt  = c_TIMER_LOAD;
                        end
                    end
                end
                INVULN: begin
                    // Hits here are absorbed: pulse only, no damage, no reload.
                    if (r_timer == '0)
                        w_state_nxt = ALIVE;
                    else
                        w_timer_nxt = r_timer - 1'b1;
                end
                DEAD: begin
                    w_state_nxt = DEAD;
                end
                default: begin
                    w_state_nxt = ALIVE;
                end
            endcase
        end
    end

    assign player_hit  = r_hit;
    assign health      = r_health;
    assign invuln      = (r_state == INVULN);
    assign player_dead = (r_state == DEAD);

    always_comb begin
        visible = 1'b1;
        case (r_state)
            ALIVE:   visible = 1'b1;
            INVULN:  visible = ~r_timer[BLINK_BIT];
            DEAD:    visible = 1'b0;
            default: visible = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/player_damage.md
Name: player_damage

Overview:
- Target-side responder for the projectile interface; one instance per player.
- Each frame it tests the opposing player's live bullet against this player's box.
- On a hit it returns a one-frame player_hit pulse to the bullet so the bullet despawns.
- It also tracks health, runs an invulnerability window with sprite blink, and latches death until the next round.

Parameters:
MAX_HEALTH, 3, health loaded at reset and round_start (1..7).
INVULN_FRAMES, 60, frames of invulnerability after a damaging hit (>=1).
BLINK_BIT, 2, timer bit driving blink; visible toggles every 2^BLINK_BIT frames.

Ports:
frame_clk  in  1  frame-rate clock, all state on rising edge.
Reset_n  in  1  asynchronous, active-low reset.
round_start  in  1  synchronous pulse: restore health, return to ALIVE.
BallX  in  10  player centre X.
BallY  in  10  player centre Y.
BallS  in  10  player half-size.
BulletX  in  10  opposing bullet centre X.
BulletY  in  10  opposing bullet centre Y.
BulletS  in  10  opposing bullet half-size.
bullet_on  in  1  opposing bullet active.
player_hit  out  1  registered one-cycle hit pulse to the opposing bullet.
health  out  3  remaining health.
invuln  out  1  high while in INVULN.
visible  out  1  sprite draw enable.
player_dead  out  1  high while in DEAD.

Behaviour:
- Reset (Reset_n=0, async):
  - state=ALIVE, health=MAX_HEALTH, timer=0.
  - player_hit=0, invuln=0, visible=1, player_dead=0.
- Overlap (combinational):
  - Zero-extend all operands to 11 bits.
  - dx=|BulletX-BallX|, dy=|BulletY-BallY|.
  - overlap = bullet_on && dx < BulletS+BallS && dy < BulletS+BallS.
  - Touching edges (dx == sum) is not a hit.
- hit_ok = overlap && state!=DEAD && player_hit==0.
  - The pulse cannot repeat on the edge right after it.
  - This covers the bullet's one-frame despawn lag.
- player_hit <= hit_ok, so it is high for exactly one cycle after the sampling edge.
- ALIVE:
  - On hit_ok, health <= health-1.
  - If health==1, go to DEAD (health=0).
  - Otherwise go to INVULN with timer <= INVULN_FRAMES-1.
- INVULN:
  - timer decrements each edge; when timer==0 at an edge, go to ALIVE.
  - hit_ok still pulses player_hit (the bullet is absorbed).
  - No damage, and the timer is not reloaded.
- DEAD:
  - Absorbing state; player_hit is never asserted and the bullet passes through.
  - Left only via round_start or reset.
- round_start has priority over every event on the same edge:
  - state=ALIVE, health=MAX_HEALTH, timer=0, player_hit<=0.
- Outputs are combinational from registered state:
  - invuln = (state==INVULN); player_dead = (state==DEAD).
  - visible = 1 in ALIVE, ~timer[BLINK_BIT] in INVULN, 0 in DEAD.
- Health never underflows and never exceeds MAX_HEALTH.
- Reset mid-INVULN returns to reset values immediately.

Decomposition:
- game_pkg:
  - typedef enum logic [1:0] player_state_t {ALIVE, INVULN, DEAD}.
  - Shared constants for default MAX_HEALTH and INVULN_FRAMES.
  - Timer width = $clog2(INVULN_FRAMES).
- Sub-module box_overlap: purely combinational 11-bit abs-difference box test, reusable for barrier collision.

Test Plan:
- Reset_n pulsed low mid-run -> health=3, player_hit=0, visible=1, invuln=0, player_dead=0 with no clock edge.
- Ball(320,240,S4), bullet(326,240,S4,on) for 1 edge -> player_hit high exactly 1 cycle, health 3->2, invuln=1. Overlap held 5 edges -> further pulses only on alternate cycles, health stays 2.
- Boundary: BulletX=328 (dx=8) -> no hit. BulletX=327 (dx=7) -> hit. Ball at X=2 with bullet X=9 (dx=7) -> hit, with no wrap error.
- After a hit, count frames -> invuln drops after exactly 60 edges, visible toggles every 4 frames meanwhile. Overlap at frame 61 -> health 2->1.
- Three damaging hits spaced >60 frames -> health=0, player_dead=1, visible=0. Later overlaps -> player_hit stays 0.
- In DEAD, round_start and overlap on same edge -> health=3, state ALIVE, player_hit=0. Next overlap edge -> normal hit.
